// File: rtl/bsg_hbm_channel_arbiter_pkg.sv
// Shared types for the HBM channel arbiter: FSM state encoding and the
// requester-ID (tag) width helper.
package bsg_hbm_channel_arbiter_pkg;

    typedef enum logic [1:0] {
        eIdle = 2'd0,
        eCmd  = 2'd1,
        eData = 2'd2
    } arb_state_e;

    function automatic int tag_width(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/bsg_hbm_channel_arbiter_if.sv
// Requester-side and HBM-side signal bundle of the channel arbiter.
// The slave modport is the arbiter's view; master is its surroundings.
interface bsg_hbm_channel_arbiter_if
    import bsg_hbm_channel_arbiter_pkg::*;
#(
    parameter int num_req_p            = 4,
    parameter int channel_addr_width_p = 29,
    parameter int data_width_p         = 512
);
    logic [num_req_p-1:0]                           v_i;
    logic [num_req_p-1:0]                           write_not_read_i;
    logic [num_req_p-1:0][channel_addr_width_p-1:0] ch_addr_i;
    logic [num_req_p-1:0][data_width_p-1:0]         data_i;
    logic [num_req_p-1:0]                           yumi_o;
    logic [num_req_p-1:0]                           data_v_o;
    logic [data_width_p-1:0]                        data_o;

    logic                            hbm_v_o;
    logic                            hbm_write_not_read_o;
    logic [channel_addr_width_p-1:0] hbm_ch_addr_o;
    logic                            hbm_yumi_i;
    logic                            hbm_data_v_o;
    logic [data_width_p-1:0]         hbm_data_o;
    logic                            hbm_data_yumi_i;
    logic                            hbm_data_v_i;
    logic [data_width_p-1:0]         hbm_data_i;

    modport slave (
        input  v_i, write_not_read_i, ch_addr_i, data_i,
        output yumi_o, data_v_o, data_o,
        output hbm_v_o, hbm_write_not_read_o, hbm_ch_addr_o,
        input  hbm_yumi_i,
        output hbm_data_v_o, hbm_data_o,
        input  hbm_data_yumi_i, hbm_data_v_i, hbm_data_i
    );

    modport master (
        output v_i, write_not_read_i, ch_addr_i, data_i,
        input  yumi_o, data_v_o, data_o,
        input  hbm_v_o, hbm_write_not_read_o, hbm_ch_addr_o,
        output hbm_yumi_i,
        input  hbm_data_v_o, hbm_data_o,
        output hbm_data_yumi_i, hbm_data_v_i, hbm_data_i
    );
endinterface

// File: rtl/bsg_hbm_arb_checker.sv
// Protocol checks for the channel arbiter: stray read returns and
// overlapping command/data beats.
module bsg_hbm_arb_checker (
    input logic clk_i,
    input logic reset_n_i,
    input logic ret_v,
    input logic tag_empty,
    input logic cmd_v,
    input logic wdata_v
);
    // Sampled once per cycle outside reset.
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!(ret_v && tag_empty))
                else $error("hbm read return with no outstanding read; data dropped");
            assert (!(cmd_v && wdata_v))
                else $error("hbm command and write data asserted together");
        end
    end
endmodule

// File: rtl/bsg_hbm_arb_tag_fifo.sv
// In-order FIFO of requester IDs for outstanding reads; a push and a pop in
// the same cycle are both honoured.
module bsg_hbm_arb_tag_fifo
    import bsg_hbm_channel_arbiter_pkg::*;
#(
    parameter int els_p   = 16,
    parameter int width_p = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               push_i,
    input  logic [width_p-1:0] data_i,
    input  logic               pop_i,
    output logic [width_p-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam logic [ptr_w:0] full_cnt_c = (ptr_w + 1)'(els_p);

    logic [width_p-1:0] mem_r [els_p];
    logic [ptr_w-1:0]   wptr_r, rptr_r;
    logic [ptr_w:0]     count_r;
    logic               push_s, pop_s;

    assign pop_s   = pop_i & ~empty_o;
    assign push_s  = push_i & (~full_o | pop_s);
    assign full_o  = (count_r == full_cnt_c);
    assign empty_o = (count_r == {(ptr_w + 1){1'b0}});
    assign data_o  = mem_r[rptr_r];

    // Tag storage; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wptr_r] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= {ptr_w{1'b0}};
            rptr_r  <= {ptr_w{1'b0}};
            count_r <= {(ptr_w + 1){1'b0}};
        end else begin
            if (push_s) wptr_r <= wptr_r + ptr_w'(1);
            if (pop_s)  rptr_r <= rptr_r + ptr_w'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (ptr_w + 1)'(1);
                2'b01:   count_r <= count_r - (ptr_w + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/bsg_hbm_channel_arbiter.sv
// Round-robin sharing of one HBM channel among num_req_p requesters, with
// in-order steering of read returns through a requester-ID tag FIFO.
module bsg_hbm_channel_arbiter
    import bsg_hbm_channel_arbiter_pkg::*;
#(
    parameter int num_req_p            = 4,
    parameter int channel_addr_width_p = 29,
    parameter int data_width_p         = 512,
    parameter int max_reads_p          = 16
) (
    input logic                      clk_i,
    input logic                      reset_n_i,
    bsg_hbm_channel_arbiter_if.slave bus
);
    localparam int tag_w = tag_width(num_req_p);
    typedef logic [tag_w-1:0] tag_t;
    localparam logic [num_req_p-1:0] one_c = {{(num_req_p - 1){1'b0}}, 1'b1};

    function automatic tag_t rr_idx(input tag_t base, input int offset);
        return tag_t'((int'(base) + offset) % num_req_p);
    endfunction

    arb_state_e           state_r;
    tag_t                 rr_ptr_r, gnt_id_r, winner_s, tag_head_s;
    logic                 found_s, tag_full_s, tag_empty_s;
    logic                 read_done_s, write_done_s, pop_s;
    logic [num_req_p-1:0] eligible_s;

    assign eligible_s = bus.v_i & (bus.write_not_read_i | {num_req_p{~tag_full_s}});

    // First eligible requester at or after rr_ptr_r, wrapping around.
    always_comb begin
        found_s  = 1'b0;
        winner_s = rr_ptr_r;
        for (int k = 0; k < num_req_p; k++) begin
            if (!found_s && eligible_s[rr_idx(rr_ptr_r, k)]) begin
                found_s  = 1'b1;
                winner_s = rr_idx(rr_ptr_r, k);
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Grant / command beat / data beat sequencing.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r  <= eIdle;
            rr_ptr_r <= {tag_w{1'b0}};
            gnt_id_r <= {tag_w{1'b0}};
        end else begin
            case (state_r)
                eIdle: if (found_s) begin
                    gnt_id_r <= winner_s;
                    rr_ptr_r <= rr_idx(winner_s, 1);
                    state_r  <= eCmd;
                end
                eCmd: if (bus.hbm_yumi_i) begin
                    state_r <= bus.write_not_read_i[gnt_id_r] ? eData : eIdle;
                end
                eData: if (bus.hbm_data_yumi_i) begin
                    state_r <= eIdle;
                end
                default: state_r <= eIdle;
            endcase
        end
    end

    assign read_done_s  = (state_r == eCmd) & bus.hbm_yumi_i & ~bus.write_not_read_i[gnt_id_r];
    assign write_done_s = (state_r == eData) & bus.hbm_data_yumi_i;
    assign pop_s        = bus.hbm_data_v_i & ~tag_empty_s;

    // Payload is muxed from the granted requester and held at zero when idle.
    assign bus.hbm_v_o              = (state_r == eCmd);
    assign bus.hbm_write_not_read_o = bus.hbm_v_o & bus.write_not_read_i[gnt_id_r];
    assign bus.hbm_ch_addr_o        = bus.hbm_v_o ? bus.ch_addr_i[gnt_id_r]
                                                  : {channel_addr_width_p{1'b0}};
    assign bus.hbm_data_v_o         = (state_r == eData);
    assign bus.hbm_data_o           = bus.hbm_data_v_o ? bus.data_i[gnt_id_r]
                                                       : {data_width_p{1'b0}};
    assign bus.yumi_o   = (read_done_s | write_done_s) ? (one_c << gnt_id_r) : {num_req_p{1'b0}};
    assign bus.data_v_o = pop_s ? (one_c << tag_head_s) : {num_req_p{1'b0}};
    assign bus.data_o   = pop_s ? bus.hbm_data_i : {data_width_p{1'b0}};

    bsg_hbm_arb_tag_fifo #(
        .els_p  (max_reads_p),
        .width_p(tag_w)
    ) tag_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .push_i   (read_done_s),
        .data_i   (gnt_id_r),
        .pop_i    (pop_s),
        .data_o   (tag_head_s),
        .full_o   (tag_full_s),
        .empty_o  (tag_empty_s)
    );

    bsg_hbm_arb_checker checker_inst (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .ret_v    (bus.hbm_data_v_i),
        .tag_empty(tag_empty_s),
        .cmd_v    (bus.hbm_v_o),
        .wdata_v  (bus.hbm_data_v_o)
    );
endmodule

// File: tb/tb_bsg_hbm_channel_arbiter.sv
// Directed and randomized bench for bsg_hbm_channel_arbiter against a
// transaction-level reference model (pending requests, rr pointer, tag queue).
module tb_bsg_hbm_channel_arbiter;
    localparam int N    = 4;
    localparam int AW   = 29;
    localparam int DW   = 512;
    localparam int MAXR = 16;
    typedef logic [1:0] id_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    bsg_hbm_channel_arbiter_if #(.num_req_p(N), .channel_addr_width_p(AW), .data_width_p(DW)) bus ();

    bsg_hbm_channel_arbiter #(
        .num_req_p(N), .channel_addr_width_p(AW), .data_width_p(DW), .max_reads_p(MAXR)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(reset_n),
        .bus      (bus)
    );

    // Requester and HBM stimulus state.
    logic [N-1:0]  req_v, req_w;
    logic [AW-1:0] req_addr [N];
    logic [DW-1:0] req_data [N];
    logic          hbm_yumi, hbm_dyumi, ret_v;
    logic [DW-1:0] ret_data;

    // Reference model: in-flight transaction, rr pointer, outstanding-read IDs.
    bit  m_busy, m_cmd_sent;
    id_t m_cur;
    int  m_ptr;
    id_t tagq[$];

    logic [N-1:0]  obs_yumi, obs_dv;
    logic          obs_hv, obs_hdv;
    logic [DW-1:0] obs_data;
    int yumi_cnt[N];
    int hv_cnt, hdv_cnt;
    int checks, errors;
    id_t gnt_log[$];
    int iss[N];

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] d;
        for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom();
        return d;
    endfunction

    function automatic id_t first_one(input logic [N-1:0] v);
        id_t r = 2'd0;
        for (int i = N - 1; i >= 0; i--) if (v[i]) r = id_t'(i);
        return r;
    endfunction

    task automatic raise(input id_t id, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_v[id] = 1'b1; req_w[id] = w; req_addr[id] = a; req_data[id] = d;
    endtask

    task automatic drive();
        bus.v_i = req_v;
        bus.write_not_read_i = req_w;
        for (int i = 0; i < N; i++) begin
            bus.ch_addr_i[i] = req_addr[i];
            bus.data_i[i]    = req_data[i];
        end
        bus.hbm_yumi_i = hbm_yumi;
        bus.hbm_data_yumi_i = hbm_dyumi;
        bus.hbm_data_v_i = ret_v;
        bus.hbm_data_i = ret_data;
    endtask

    task automatic model_reset();
        m_busy = 1'b0; m_cmd_sent = 1'b0; m_cur = 2'd0; m_ptr = 0;
        tagq.delete();
        req_v = 4'b0000; req_w = 4'b0000;
        hbm_yumi = 1'b0; hbm_dyumi = 1'b0; ret_v = 1'b0; ret_data = {DW{1'b0}};
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step();
        logic [N-1:0] exp_yumi, exp_dv;
        logic exp_hv, exp_hdv;
        int occ;
        @(negedge clk);
        drive();
        #1;
        occ      = tagq.size();
        exp_hv   = m_busy && !m_cmd_sent;
        exp_hdv  = m_busy && m_cmd_sent;
        exp_yumi = 4'b0000;
        if (exp_hv && hbm_yumi && !req_w[m_cur]) exp_yumi = 4'b0001 << m_cur;
        if (exp_hdv && hbm_dyumi) exp_yumi = 4'b0001 << m_cur;
        exp_dv = (ret_v && occ > 0) ? (4'b0001 << tagq[0]) : 4'b0000;

        obs_yumi = bus.yumi_o; obs_dv = bus.data_v_o; obs_data = bus.data_o;
        obs_hv = bus.hbm_v_o; obs_hdv = bus.hbm_data_v_o;
        chk("hbm_v_o", obs_hv, exp_hv);
        chk("hbm_data_v_o", obs_hdv, exp_hdv);
        chk("yumi_o", obs_yumi, exp_yumi);
        chk("data_v_o", obs_dv, exp_dv);
        chk("cmd_data_exclusive", obs_hv & obs_hdv, 1'b0);
        if (exp_hv) begin
            chk("hbm_ch_addr_o", bus.hbm_ch_addr_o, req_addr[m_cur]);
            chk("hbm_write_not_read_o", bus.hbm_write_not_read_o, req_w[m_cur]);
        end
        if (exp_hdv) chk("hbm_data_o", bus.hbm_data_o, req_data[m_cur]);
        if (exp_dv != 4'b0000) chk("data_o", obs_data, ret_data);
        for (int i = 0; i < N; i++) if (obs_yumi[i]) yumi_cnt[i]++;
        if (obs_hv) hv_cnt++;
        if (obs_hdv) hdv_cnt++;

        if (ret_v && occ > 0) void'(tagq.pop_front());
        if (!m_busy) begin
            for (int k = 0; k < N; k++) begin
                id_t idx = id_t'((m_ptr + k) % N);
                if (req_v[idx] && (req_w[idx] || occ < MAXR)) begin
                    m_busy = 1'b1; m_cmd_sent = 1'b0; m_cur = idx; m_ptr = (int'(idx) + 1) % N;
                    break;
                end
            end
        end else if (!m_cmd_sent) begin
            if (hbm_yumi) begin
                if (req_w[m_cur]) m_cmd_sent = 1'b1;
                else begin
                    tagq.push_back(m_cur); req_v[m_cur] = 1'b0; m_busy = 1'b0;
                end
            end
        end else if (hbm_dyumi) begin
            req_v[m_cur] = 1'b0; m_busy = 1'b0;
        end
    endtask

    task automatic run_until_yumi(input id_t id, input int budget);
        bit got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            step();
            got = obs_yumi[id];
        end
        chk("yumi_wait", got, 1'b1);
    endtask

    task automatic drain();
        for (int c = 0; c < 40 && tagq.size() > 0; c++) begin
            ret_v = 1'b1; ret_data = rand_data();
            step();
        end
        ret_v = 1'b0;
        chk("drain_done", tagq.size(), 0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < N; i++) yumi_cnt[i] = 0;
        hv_cnt = 0; hdv_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        model_reset();
        for (int i = 0; i < N; i++) begin req_addr[i] = {AW{1'b0}}; req_data[i] = {DW{1'b0}}; end
        clear_counts();
        reset_n = 1'b0;
        drive();
        #2;
        chk("reset_hbm_v", bus.hbm_v_o, 1'b0);
        chk("reset_hbm_data_v", bus.hbm_data_v_o, 1'b0);
        chk("reset_yumi", bus.yumi_o, 4'b0000);
        chk("reset_data_v", bus.data_v_o, 4'b0000);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Round-robin fairness: continuous reads from everyone.
        hbm_yumi = 1'b1;
        for (int i = 0; i < N; i++) begin raise(id_t'(i), 1'b0, AW'($urandom()), {DW{1'b0}}); iss[i] = 1; end
        for (int c = 0; c < 80 && gnt_log.size() < 12; c++) begin
            step();
            if (obs_yumi != 4'b0000) begin
                gnt_log.push_back(first_one(obs_yumi));
                for (int i = 0; i < N; i++)
                    if (obs_yumi[i] && iss[i] < 3) begin
                        raise(id_t'(i), 1'b0, AW'($urandom()), {DW{1'b0}}); iss[i]++;
                    end
            end
        end
        chk("rr_grants", gnt_log.size(), 12);
        foreach (gnt_log[k]) chk("rr_order", gnt_log[k], k % N);
        drain();

        // Single read from requester 2.
        raise(2'd2, 1'b0, 29'h40, {DW{1'b0}});
        step();
        chk("rd_idle_hv", obs_hv, 1'b0);
        step();
        chk("rd_hv", obs_hv, 1'b1);
        chk("rd_yumi", obs_yumi, 4'b0100);
        repeat (9) step();
        ret_v = 1'b1; ret_data = 512'hAB;
        step();
        chk("rd_data_v", obs_dv, 4'b0100);
        chk("rd_data", obs_data, 512'hAB);
        ret_v = 1'b0;

        // Single write from requester 1 with a slow data accept.
        clear_counts();
        raise(2'd1, 1'b1, 29'h80, 512'h1234);
        hbm_dyumi = 1'b0;
        step(); step();
        step(); step();
        hbm_dyumi = 1'b1;
        step();
        chk("wr_yumi", obs_yumi, 4'b0010);
        step();
        chk("wr_data_v_cycles", hdv_cnt, 3);
        chk("wr_cmd_cycles", hv_cnt, 1);
        chk("wr_yumi_once", yumi_cnt[1], 1);

        // Out-of-order issue, in-order return, push+pop in one cycle.
        raise(2'd3, 1'b0, AW'($urandom()), {DW{1'b0}}); run_until_yumi(2'd3, 6);
        raise(2'd1, 1'b1, AW'($urandom()), rand_data()); run_until_yumi(2'd1, 8);
        raise(2'd0, 1'b0, AW'($urandom()), {DW{1'b0}}); run_until_yumi(2'd0, 6);
        raise(2'd1, 1'b1, AW'($urandom()), rand_data()); run_until_yumi(2'd1, 8);
        raise(2'd2, 1'b0, AW'($urandom()), {DW{1'b0}}); run_until_yumi(2'd2, 6);
        raise(2'd1, 1'b0, AW'($urandom()), {DW{1'b0}});
        step();
        ret_v = 1'b1; ret_data = rand_data();
        step();
        chk("pp_yumi", obs_yumi, 4'b0010);
        chk("ooo_ret0", obs_dv, 4'b1000);
        ret_data = rand_data(); step(); chk("ooo_ret1", obs_dv, 4'b0001);
        ret_data = rand_data(); step(); chk("ooo_ret2", obs_dv, 4'b0100);
        ret_data = rand_data(); step(); chk("ooo_ret3", obs_dv, 4'b0010);
        ret_v = 1'b0;

        // Tag FIFO full: the write proceeds, the 17th read waits for a pop.
        for (int k = 0; k < MAXR; k++) begin
            raise(2'd0, 1'b0, AW'($urandom()), {DW{1'b0}}); run_until_yumi(2'd0, 6);
        end
        clear_counts();
        raise(2'd0, 1'b0, AW'($urandom()), {DW{1'b0}});
        raise(2'd3, 1'b1, AW'($urandom()), rand_data());
        run_until_yumi(2'd3, 10);
        repeat (4) step();
        chk("full_stall", yumi_cnt[0], 0);
        ret_v = 1'b1; ret_data = rand_data();
        step();
        chk("full_pop", obs_dv, 4'b0001);
        ret_v = 1'b0;
        run_until_yumi(2'd0, 6);
        drain();

        // Reset in the middle of a write data beat.
        raise(2'd2, 1'b0, AW'($urandom()), {DW{1'b0}}); run_until_yumi(2'd2, 6);
        raise(2'd1, 1'b1, AW'($urandom()), rand_data());
        hbm_dyumi = 1'b0;
        step(); step(); step();
        chk("mid_data_beat", obs_hdv, 1'b1);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("rst_hbm_v", bus.hbm_v_o, 1'b0);
        chk("rst_hbm_data_v", bus.hbm_data_v_o, 1'b0);
        chk("rst_hbm_data", bus.hbm_data_o, {DW{1'b0}});
        chk("rst_hbm_addr", bus.hbm_ch_addr_o, {AW{1'b0}});
        chk("rst_hbm_wnr", bus.hbm_write_not_read_o, 1'b0);
        chk("rst_yumi", bus.yumi_o, 4'b0000);
        chk("rst_data_v", bus.data_v_o, 4'b0000);
        chk("rst_data", bus.data_o, {DW{1'b0}});
        model_reset();
        repeat (2) @(negedge clk);
        drive();
        reset_n = 1'b1;
        hbm_yumi = 1'b1;
        raise(2'd0, 1'b0, AW'($urandom()), {DW{1'b0}});
        raise(2'd3, 1'b0, AW'($urandom()), {DW{1'b0}});
        step(); step();
        chk("rst_rr_ptr", obs_yumi, 4'b0001);
        run_until_yumi(2'd3, 6);
        ret_v = 1'b1; ret_data = rand_data();
        step(); chk("rst_tag_head", obs_dv, 4'b0001);
        ret_data = rand_data();
        step(); chk("rst_tag_next", obs_dv, 4'b1000);
        ret_v = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (!req_v[i] && ($urandom() % 4 == 0))
                    raise(id_t'(i), 1'($urandom() % 2), AW'($urandom()), rand_data());
            hbm_yumi  = 1'(($urandom() % 3) != 0);
            hbm_dyumi = 1'($urandom() % 2);
            ret_v     = (tagq.size() > 0) && ($urandom() % 3 == 0);
            ret_data  = rand_data();
            step();
        end
        ret_v = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
